kulkarni_mult_8x8: RTL and testbench

- Unsigned 8x8 -> 16-bit approximate multiplier using the Kulkarni underdesigned 2x2 building block, where 3x3 yields 7 instead of 9.
- Blocks compose hierarchically: 2x2 -> 4x4 -> 8x8, with exact partial-product addition.
- Sits in the low-power arithmetic datapath, where small product error is tolerated.
- Single output register stage gives a fixed 1-cycle latency with a valid qualifier.

---
 rtl/kulkarni_mult_8x8_if.sv | 41 ++++
 rtl/kulkarni_mult_8x8.sv | 118 +++++++++++
 tb/tb_kulkarni_mult_8x8.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/kulkarni_mult_8x8_if.sv
`default_nettype none
// ============================================================================
// Module      : kulkarni_mult_8x8_if
// Description : Operand/product bundle for the Kulkarni approximate 8x8
//               multiplier. Carries approx_hit only when
//               KULKARNI_APPROX_FLAG_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface kulkarni_mult_8x8_if;
    logic        in_valid;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic [15:0] y;
`ifdef KULKARNI_APPROX_FLAG_EN
    logic        approx_hit;
`endif

    modport master (
        output in_valid,
        output a,
        output b,
`ifdef KULKARNI_APPROX_FLAG_EN
        input  approx_hit,
`endif
        input  out_valid,
        input  y
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
`ifdef KULKARNI_APPROX_FLAG_EN
        output approx_hit,
`endif
        output out_valid,
        output y
    );
endinterface
`default_nettype wire

// File: rtl/kulkarni_mult_8x8.sv
`default_nettype none
// ============================================================================
// Module      : kulkarni_mult_8x8
// Description : Unsigned 8x8 -> 16 approximate multiplier built from the
//               Kulkarni 2x2 block (3*3 -> 7), composed 2x2 -> 4x4 -> 8x8
//               with exact partial-product sums and one output register.
//               Optional approx_hit flag: define KULKARNI_APPROX_FLAG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module kulkarni_mult_8x8 (
    input  wire                   clk,
    input  wire                   rst,
    kulkarni_mult_8x8_if.slave    bus
);

    // w_pp[i][j] is the 2x2 product of base-4 digit i of a and digit j of b.
    logic [3:0][3:0][2:0] w_pp;
    logic [15:0]          w_hit_vec;

    for (genvar gi = 0; gi < 4; gi++) begin : g_row
        for (genvar gj = 0; gj < 4; gj++) begin : g_col
            logic [1:0] w_p;
            logic [1:0] w_q;

            assign w_p = bus.a[2*gi +: 2];
            assign w_q = bus.b[2*gj +: 2];

            assign w_pp[gi][gj] = {
                w_p[1] & w_q[1],
                (w_p[1] & w_q[0]) | (w_p[0] & w_q[1]),
                w_p[0] & w_q[0]
            };

            assign w_hit_vec[gi*4 + gj] = &{w_p, w_q};
        end
    end

    // w_p4[ha][hb] is the 4x4 product of nibble ha of a and nibble hb of b.
    logic [1:0][1:0][7:0] w_p4;

    for (genvar ha = 0; ha < 2; ha++) begin : g_nib_a
        for (genvar hb = 0; hb < 2; hb++) begin : g_nib_b
            logic [7:0] w_hh;
            logic [7:0] w_mid;
            logic [7:0] w_ll;

            assign w_hh  = {5'd0, w_pp[2*ha+1][2*hb+1]};
            assign w_mid = {5'd0, w_pp[2*ha+1][2*hb]} + {5'd0, w_pp[2*ha][2*hb+1]};
            assign w_ll  = {5'd0, w_pp[2*ha][2*hb]};

            assign w_p4[ha][hb] = (w_hh << 4) + (w_mid << 2) + w_ll;
        end
    end

    logic [15:0] w_hh8;
    logic [15:0] w_mid8;
    logic [15:0] w_ll8;
    logic [15:0] w_prod;

    assign w_hh8  = {w_p4[1][1], 8'd0};
    assign w_mid8 = {8'd0, w_p4[1][0]} + {8'd0, w_p4[0][1]};
    assign w_ll8  = {8'd0, w_p4[0][0]};
    assign w_prod = w_hh8 + (w_mid8 << 4) + w_ll8;

    logic [15:0] y_d;
    logic [15:0] y_q;
    logic        out_valid_d;
    logic        out_valid_q;

    always_comb begin
        y_d         = y_q;
        out_valid_d = bus.in_valid;
        if (bus.in_valid) begin
            y_d = w_prod;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q         <= 16'd0;
            out_valid_q <= 1'b0;
        end else begin
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.y         = y_q;
    assign bus.out_valid = out_valid_q;

`ifdef KULKARNI_APPROX_FLAG_EN
    logic approx_hit_d;
    logic approx_hit_q;

    always_comb begin
        approx_hit_d = approx_hit_q;
        if (bus.in_valid) begin
            approx_hit_d = |w_hit_vec;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            approx_hit_q <= 1'b0;
        end else begin
            approx_hit_q <= approx_hit_d;
        end
    end

    assign bus.approx_hit = approx_hit_q;
`else
    // The sub-block hit flags only feed the optional port.
    logic w_hit_unused;
    assign w_hit_unused = ^w_hit_vec;
`endif

endmodule
`default_nettype wire

// File: tb/tb_kulkarni_mult_8x8.sv
`default_nettype none
// ============================================================================
// Module      : tb_kulkarni_mult_8x8
// Description : Scoreboard bench for kulkarni_mult_8x8 against a base-4
//               digit-sum reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kulkarni_mult_8x8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    kulkarni_mult_8x8_if bus ();

    kulkarni_mult_8x8 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit          valid;
        logic [15:0] y;
        bit          hit;
        int          exact;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    logic [15:0] held_y   = 16'd0;
    bit          held_hit = 1'b0;

    // Product as a sum over all base-4 digit pairs, each pair 3*3 scoring 7.
    function automatic int ref_prod(input int x, input int z, output bit hit);
        int sum;
        sum = 0;
        hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                int dx, dz, p;
                dx = (x >> (2*i)) & 3;
                dz = (z >> (2*j)) & 3;
                p  = dx * dz;
                if (p == 9) begin
                    p   = 7;
                    hit = 1'b1;
                end
                sum += p * (1 << (2*(i+j)));
            end
        end
        return sum;
    endfunction

    task automatic drive(input bit r, input bit v, input int ta, input int tb_op);
        exp_t e;
        bit   h;
        int   p;
        @(posedge clk);
        #1;
        rst          = r;
        bus.in_valid = v;
        bus.a        = ta[7:0];
        bus.b        = tb_op[7:0];
        if (r) begin
            held_y   = 16'd0;
            held_hit = 1'b0;
            e.valid  = 1'b0;
        end else if (v) begin
            p        = ref_prod(ta & 255, tb_op & 255, h);
            held_y   = p[15:0];
            held_hit = h;
            e.valid  = 1'b1;
        end else begin
            e.valid  = 1'b0;
        end
        e.y     = held_y;
        e.hit   = held_hit;
        e.exact = (ta & 255) * (tb_op & 255);
        q.push_back(e);
    endtask

    // Monitor: an entry queued before an edge is checked at the following negedge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (q.size() > 0) begin
                @(negedge clk);
                e = q.pop_front();
                n_vec++;
                if (bus.out_valid !== e.valid) begin
                    n_err++;
                    $display("FAIL out_valid: got %b expected %b at %0t", bus.out_valid, e.valid, $time);
                end
                if (bus.y !== e.y) begin
                    n_err++;
                    $display("FAIL y: got %0d expected %0d at %0t", bus.y, e.y, $time);
                end
                if (e.valid && (int'(bus.y) > e.exact)) begin
                    n_err++;
                    $display("FAIL y_bound: got %0d exceeds exact %0d at %0t", bus.y, e.exact, $time);
                end
`ifdef KULKARNI_APPROX_FLAG_EN
                if (bus.approx_hit !== e.hit) begin
                    n_err++;
                    $display("FAIL approx_hit: got %b expected %b at %0t", bus.approx_hit, e.hit, $time);
                end
`endif
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.a        = 8'd0;
        bus.b        = 8'd0;

        // Reset dominates a valid operand pair, then idle stays at zero.
        drive(1, 1, 255, 255);
        drive(1, 1, 255, 255);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);

        // Back-to-back exact products, then zero and approximation points.
        drive(0, 1, 10, 32);
        drive(0, 1, 20, 32);
        drive(0, 1, 10, 30);
        drive(0, 1, 0, 200);
        drive(0, 1, 3, 3);
        drive(0, 1, 15, 15);
        drive(0, 1, 255, 255);

        // Hold: inputs change while in_valid is low.
        drive(0, 1, 10, 32);
        drive(0, 0, 99, 77);
        drive(0, 0, 5, 6);

        // Reset mid-stream discards the pending product.
        drive(0, 1, 255, 255);
        drive(1, 1, 3, 3);
        drive(0, 0, 3, 3);
        drive(0, 1, 7, 13);

        for (int ia = 0; ia < 256; ia++) begin
            for (int ib = 0; ib < 256; ib++) begin
                drive(0, 1, ia, ib);
            end
        end

        for (int k = 0; k < 3000; k++) begin
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        end

        drive(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending entries expected 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
